// File: rtl/mem_arbiter.sv
// Two-port arbiter that shares one block memory between the icache (read-only) and the dcache (read/write).
// Optional macro ARB_ROUND_ROBIN_EN: alternate ties via rr_last (default build: dcache always wins ties).
module mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_i_data;
    logic [DATA_W-1:0] r_d_data;
    logic              w_req_i;
    logic              w_req_d;
    logic              w_pick_d;

    assign w_req_i = i_read;
    assign w_req_d = d_read | d_write;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_rr_last;  // 0 = icache granted last, 1 = dcache granted last

    assign w_pick_d = w_req_d & (~w_req_i | ~r_rr_last);
`else
    assign w_pick_d = w_req_d;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_i_data <= '0;
            r_d_data <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_rr_last <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_state <= GRANT_D;
                    end else if (w_req_i) begin
                        r_state <= GRANT_I;
                    end
                end
                GRANT_I: begin
                    if (!mem_busywait) begin
                        r_state  <= IDLE;
                        r_i_data <= mem_readdata;
`ifdef ARB_ROUND_ROBIN_EN
                        r_rr_last <= 1'b0;
`endif
                    end
                end
                GRANT_D: begin
                    if (!mem_busywait) begin
                        r_state  <= IDLE;
                        r_d_data <= mem_readdata;
`ifdef ARB_ROUND_ROBIN_EN
                        r_rr_last <= 1'b1;
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        case (r_state)
            GRANT_I: begin
                mem_read    = 1'b1;
                mem_address = i_address;
            end
            GRANT_D: begin
                mem_read      = d_read & ~d_write;
                mem_write     = d_write;
                mem_address   = d_address;
                mem_writedata = d_writedata;
            end
            default: ;
        endcase
    end

    // A port is released only in the completion cycle of its own grant.
    assign i_busywait = w_req_i & ~((r_state == GRANT_I) & ~mem_busywait);
    assign d_busywait = w_req_d & ~((r_state == GRANT_D) & ~mem_busywait);

    assign i_readdata = (r_state == GRANT_I) ? mem_readdata : r_i_data;
    assign d_readdata = (r_state == GRANT_D) ? mem_readdata : r_d_data;

endmodule
